// File: rtl/kyber_pm_pkg.sv
// kyber_pm_pkg: shared constants, opcodes and FSM state type for the Kyber poly-mult sequencer
package kyber_pm_pkg;
  localparam int N = 256;
  localparam int W = 12;
  localparam logic [3:0] OP_LOAD_A_F = 4'd0;
  localparam logic [3:0] OP_LOAD_A_I = 4'd1;
  localparam logic [3:0] OP_LOAD_B_F = 4'd2;
  localparam logic [3:0] OP_LOAD_B_I = 4'd3;
  localparam logic [3:0] OP_FNTT_A = 4'd4;
  localparam logic [3:0] OP_FNTT_B = 4'd5;
  localparam logic [3:0] OP_PWM2 = 4'd6;
  localparam logic [3:0] OP_INTT_A = 4'd7;
  localparam logic [3:0] OP_INTT_B = 4'd8;
  localparam logic [3:0] OP_READ_A = 4'd9;
  localparam logic [3:0] OP_READ_B = 4'd10;
  typedef enum logic [2:0] {IDLE, LD_FILL, LD_STREAM, CMP_START, CMP_WAIT, RD_WAIT, RD_STREAM, GAP} state_t;
endpackage

// File: rtl/kyber_ld_reorder.sv
// kyber_ld_reorder: two 4-word banks; writes land in natural order, reads swap the middle pair (0,2,1,3)
module kyber_ld_reorder
  import kyber_pm_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic         wr_bank,
  input  logic [1:0]   wr_slot,
  input  logic [W-1:0] wr_data,
  input  logic         rd_bank,
  input  logic [1:0]   rd_slot,
  output logic [W-1:0] rd_data
);
  logic [W-1:0] mem [8];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) for (int i = 0; i < 8; i++) mem[i] <= '0;
    else if (wr_en) mem[{wr_bank, wr_slot}] <= wr_data;
  assign rd_data = mem[{rd_bank, rd_slot[0], rd_slot[1]}];
endmodule

// File: rtl/kyber_pm_sequencer.sv
// kyber_pm_sequencer: command FSM that streams coefficients into/out of the NTT core and sequences its operations
module kyber_pm_sequencer
  import kyber_pm_pkg::*;
#(
  parameter int TIMEOUT = 8191
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  output logic [7:0]   m_idx,
  output logic [W-1:0] m_data,
  output logic         busy,
  output logic [2:0]   err,
  input  logic         err_clr,
  output logic [3:0]   core_load,
  output logic [1:0]   core_read,
  output logic [2:0]   core_start,
  output logic         core_ab,
  output logic [W-1:0] core_din,
  input  logic [W-1:0] core_dout,
  input  logic         core_done
);
  localparam int CW = $clog2(TIMEOUT) > 8 ? $clog2(TIMEOUT) : 8;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic [2:0] err_set;
  logic in_win, wr_en, done_ok;
  logic [W-1:0] rd_data;
  // words for group g+1 are due during the first 63 groups of the stream
  assign in_win = state == LD_STREAM && cnt < CW'(N - 4);
  assign done_ok = cnt >= CW'(2) && core_done;
  always_comb begin
    nxt = state;
    err_set = '0;
    case (state)
      IDLE: if (cmd_valid) begin
        nxt = cmd_op <= OP_LOAD_B_I ? LD_FILL : cmd_op <= OP_INTT_B ? CMP_START : cmd_op <= OP_READ_B ? RD_WAIT : GAP;
        err_set[0] = cmd_op > OP_READ_B;
      end
      LD_FILL: if (cnt == CW'(4)) nxt = LD_STREAM;
      LD_STREAM: begin
        err_set[1] = in_win && !s_valid;
        if (cnt == CW'(N - 1)) nxt = GAP;
      end
      CMP_START: nxt = CMP_WAIT;
      CMP_WAIT: if (done_ok || cnt == CW'(TIMEOUT - 1)) begin
        nxt = GAP;
        err_set[2] = !done_ok;
      end
      RD_WAIT: if (cnt == CW'(2)) nxt = RD_STREAM;
      RD_STREAM: if (cnt == CW'(N - 1)) nxt = GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      op <= '0;
      err <= '0;
    end else begin
      state <= nxt;
      cnt <= nxt != state ? '0 : cnt + CW'(state == LD_FILL ? s_valid && s_ready : state != IDLE);
      if (state == IDLE && cmd_valid) op <= cmd_op;
      err <= (err_clr ? 3'b000 : err) | err_set;
    end
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign s_ready = (state == LD_FILL && cnt < CW'(4)) || in_win;
  // a missing stream word is still written, as 0, so the bank stays in step
  assign wr_en = s_ready && (s_valid || state == LD_STREAM);
  kyber_ld_reorder u_reorder (
    .clk(clk),
    .reset_n(reset_n),
    .wr_en(wr_en),
    .wr_bank(state == LD_STREAM && !cnt[2]),
    .wr_slot(cnt[1:0]),
    .wr_data(s_valid ? s_data : '0),
    .rd_bank(cnt[2]),
    .rd_slot(cnt[1:0]),
    .rd_data(rd_data)
  );
  assign core_din = state == LD_STREAM ? rd_data : '0;
  assign core_load = state == LD_FILL && cnt == CW'(4) ? 4'b0001 << op[1:0] : 4'b0000;
  assign core_start = state != CMP_START ? 3'b000 : op == OP_PWM2 ? 3'b010 : op <= OP_FNTT_B ? 3'b001 : 3'b100;
  assign core_ab = state == CMP_START && (op == OP_FNTT_B || op == OP_INTT_B);
  assign core_read = state == RD_WAIT && cnt == '0 ? (op == OP_READ_B ? 2'b10 : 2'b01) : 2'b00;
  assign m_valid = state == RD_STREAM;
  assign m_idx = m_valid ? {cnt[0], cnt[7:1]} : 8'd0;
  assign m_data = m_valid ? core_dout : '0;
endmodule

// File: tb/tb_kyber_pm_sequencer.sv
// tb_kyber_pm_sequencer: directed self-checking bench for the Kyber poly-mult sequencer
module tb_kyber_pm_sequencer;
  import kyber_pm_pkg::*;
  logic clk = 0, reset_n = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [3:0] cmd_op = 0;
  logic s_valid = 0, s_ready;
  logic [11:0] s_data = 0;
  logic m_valid;
  logic [7:0] m_idx;
  logic [11:0] m_data;
  logic busy;
  logic [2:0] err;
  logic err_clr = 0;
  logic [3:0] core_load;
  logic [1:0] core_read;
  logic [2:0] core_start;
  logic core_ab;
  logic [11:0] core_din;
  logic [11:0] cyc = 0;
  logic core_done = 0;
  int checks = 0, errors = 0;

  kyber_pm_sequencer dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_idx(m_idx),
    .m_data(m_data), .busy(busy), .err(err), .err_clr(err_clr), .core_load(core_load),
    .core_read(core_read), .core_start(core_start), .core_ab(core_ab), .core_din(core_din),
    .core_dout(cyc), .core_done(core_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 12'd1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op);
    cmd_valid = 1;
    cmd_op = op;
    chk("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic do_load(input logic [3:0] op, input int drop, input int stop, input logic [2:0] exp_err);
    int idx, k, strobes, e;
    idx = 0;
    k = -1;
    strobes = 0;
    send_cmd(op);
    for (int c = 0; c < 300 && k < 256; c++) begin
      if (idx == stop) begin
        s_valid = 0;
        return;
      end
      if (k >= 0) begin
        e = (k & ~3) | ((k & 1) << 1) | ((k >> 1) & 1);
        chk("ld_din", core_din, e == drop ? 0 : e);
        k++;
      end
      if (core_load != 0) begin
        chk("ld_strobe", core_load, 4'b0001 << op[1:0]);
        strobes++;
        if (k < 0) k = 0;
      end
      s_valid = idx != drop;
      s_data = idx[11:0];
      if (s_ready) idx++;
      @(negedge clk);
    end
    s_valid = 0;
    chk("ld_len", k, 256);
    chk("ld_strobes", strobes, 1);
    chk("ld_words", idx, 256);
    chk("ld_gap_busy", busy, 1);
    chk("ld_gap_sready", s_ready, 0);
    chk("ld_gap_din", core_din, 0);
    @(negedge clk);
    chk("ld_idle", busy, 0);
    chk("ld_err", err, exp_err);
  endtask

  initial begin
    int t, first, beats, reads;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_din", core_din, 0);
    chk("rst_midx", m_idx, 0);
    chk("rst_strobes", {core_load, core_read, core_start, core_ab, m_valid}, 0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    do_load(OP_LOAD_A_I, -1, -1, 3'b000);

    send_cmd(OP_INTT_B);
    chk("intt_start", core_start, 3'b100);
    chk("intt_ab", core_ab, 1);
    for (int i = 1; i <= 902; i++) begin
      @(negedge clk);
      if (i == 1) chk("intt_start_once", {core_start, core_ab}, 0);
      if (i == 900) core_done = 1;
      if (i == 901) chk("intt_gap", busy, 1);
      if (i == 902) chk("intt_idle", busy, 0);
    end
    core_done = 0;

    core_done = 1;
    send_cmd(OP_PWM2);
    chk("pwm_start", core_start, 3'b010);
    chk("pwm_ab", core_ab, 0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) chk("pwm_ignore_done", busy, 1);
      if (i == 4) chk("pwm_gap", busy, 1);
      if (i == 5) chk("pwm_idle", busy, 0);
    end
    core_done = 0;

    send_cmd(OP_READ_A);
    chk("rd_strobe", core_read, 2'b01);
    first = -1;
    beats = 0;
    reads = 0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge clk);
      if (core_read != 0) reads++;
      if (m_valid) begin
        if (first < 0) first = i;
        chk("rd_idx", m_idx, (beats >> 1) | ((beats & 1) << 7));
        chk("rd_data", m_data, cyc);
        beats++;
      end
    end
    chk("rd_first", first, 3);
    chk("rd_beats", beats, 256);
    chk("rd_reads", reads, 0);
    chk("rd_idle", busy, 0);

    do_load(OP_LOAD_B_F, 100, -1, 3'b010);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    chk("err_clr", err, 0);

    send_cmd(OP_FNTT_A);
    chk("fntt_start", core_start, 3'b001);
    chk("fntt_ab", core_ab, 0);
    t = 0;
    while (!err[2] && t < 9000) begin
      @(negedge clk);
      t++;
    end
    chk("to_cycles", t, 8192);
    @(negedge clk);
    chk("to_idle", busy, 0);
    chk("to_err", err, 3'b100);

    err_clr = 1;
    send_cmd(4'd13);
    err_clr = 0;
    chk("ill_err_set_wins", err, 3'b001);
    chk("ill_gap", busy, 1);
    chk("ill_no_strobe", {core_load, core_read, core_start, core_ab}, 0);
    @(negedge clk);
    chk("ill_idle", busy, 0);

    do_load(OP_LOAD_A_F, -1, 50, 3'b000);
    reset_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_sready", s_ready, 0);
    chk("abort_err", err, 0);
    chk("abort_din", core_din, 0);
    chk("abort_strobes", {core_load, core_read, core_start, core_ab, m_valid}, 0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    do_load(OP_LOAD_B_I, -1, -1, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
